// File: rtl/memory_access_pkg.sv
// Shared types and defaults for the MEM pipeline stage: FSM state encodings,
// default geometry and a small address helper.
package memory_access_pkg;

   typedef enum logic [1:0] {
      MEM_IDLE    = 2'd0,
      MEM_WAIT    = 2'd1,
      MEM_RECOVER = 2'd2
   } mem_state_e;

   localparam int DEFAULT_ADDR_W  = 10;
   localparam int DEFAULT_TIMEOUT = 16;

   function automatic logic word_aligned(input logic [31:0] byte_addr);
      return (byte_addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/memory_access_if.sv
// Variable-latency req/ack data-memory port between the MEM stage (master)
// and the data memory (slave).
interface memory_access_if
   import memory_access_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W
) ();

   logic              dmem_req;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [31:0]       dmem_wdata;
   logic [31:0]       dmem_rdata;
   logic              dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_ack
   );

endinterface

// File: rtl/memory_access_timer.sv
// Wait-cycle counter for an outstanding data-memory request; flags the last
// cycle a request may remain unacknowledged.
module memory_access_timer
   import memory_access_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] cnt_r;

   // Count unacknowledged request cycles; cleared whenever nothing is pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (clear) begin
         cnt_r <= '0;
      end else if (inc) begin
         cnt_r <= cnt_r + CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expired = (cnt_r == CW'(TIMEOUT - 1));

endmodule

// File: rtl/memory_access.sv
// MEM stage of the 5-stage MIPS pipeline: issues loads/stores on a req/ack
// port, stalls upstream while waiting, aborts on misalignment or timeout.
module memory_access
   import memory_access_pkg::*;
#(
   parameter int ADDR_W  = DEFAULT_ADDR_W,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           alu_data_ex_mem,
   input  logic [31:0]           rt_data_ex_mem,
   input  logic                  mem_en_ex_mem,
   input  logic                  rd_en_ex_mem,
   input  logic [4:0]            rd_addr_ex_mem,
   input  logic                  rd_data_sel_ex_mem,
   output logic                  mem_stall,
   memory_access_if.master       dmem,
   output logic                  rd_en_mem_wb,
   output logic [4:0]            rd_addr_mem_wb,
   output logic [31:0]           rd_data_mem_wb,
   output logic                  mem_err_mem_wb
);

   mem_state_e state_r;
   logic       acc_s;
   logic       misalign_s;
   logic       req_s;
   logic       complete_s;
   logic       abort_s;
   logic       stall_s;
   logic       expired_s;
   logic       timer_inc_s;
   logic       timer_clear_s;

   memory_access_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (timer_clear_s),
      .inc     (timer_inc_s),
      .expired (expired_s)
   );

   // Request/stall decode; req and stall are forced low while in reset.
   always_comb begin
      acc_s      = mem_en_ex_mem & word_aligned(alu_data_ex_mem);
      misalign_s = mem_en_ex_mem & ~word_aligned(alu_data_ex_mem);
      case (state_r)
         MEM_IDLE:    req_s = acc_s;
         MEM_WAIT:    req_s = 1'b1;
         MEM_RECOVER: req_s = 1'b0;
         default:     req_s = 1'b0;
      endcase
      req_s         = req_s & rst_n;
      complete_s    = req_s & dmem.dmem_ack;
      abort_s       = (state_r == MEM_WAIT) & ~dmem.dmem_ack & expired_s;
      stall_s       = rst_n & ((acc_s & ~dmem.dmem_ack & ~abort_s) | (state_r == MEM_RECOVER));
      timer_inc_s   = req_s & ~dmem.dmem_ack & ~abort_s;
      timer_clear_s = ~timer_inc_s;
   end

   assign mem_stall       = stall_s;
   assign dmem.dmem_req   = req_s;
   assign dmem.dmem_we    = mem_en_ex_mem & ~rd_en_ex_mem;
   assign dmem.dmem_addr  = alu_data_ex_mem[ADDR_W+1:2];
   assign dmem.dmem_wdata = rt_data_ex_mem;

   // Access FSM and mem->wb pipeline registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= MEM_IDLE;
         rd_en_mem_wb   <= 1'b0;
         rd_addr_mem_wb <= 5'd0;
         rd_data_mem_wb <= 32'd0;
         mem_err_mem_wb <= 1'b0;
      end else begin
         case (state_r)
            MEM_IDLE: begin
               if (acc_s && !dmem.dmem_ack) begin
                  state_r <= MEM_WAIT;
               end else begin
                  state_r <= MEM_IDLE;
               end
            end
            MEM_WAIT: begin
               // Ack takes priority over an expiring timer in the same cycle.
               if (dmem.dmem_ack) begin
                  state_r <= MEM_IDLE;
               end else if (expired_s) begin
                  state_r <= MEM_RECOVER;
               end else begin
                  state_r <= MEM_WAIT;
               end
            end
            MEM_RECOVER: state_r <= MEM_IDLE;
            default:     state_r <= MEM_IDLE;
         endcase

         if (complete_s) begin
            rd_en_mem_wb   <= rd_en_ex_mem;
            rd_addr_mem_wb <= rd_addr_ex_mem;
            rd_data_mem_wb <= rd_data_sel_ex_mem ? dmem.dmem_rdata : alu_data_ex_mem;
            mem_err_mem_wb <= 1'b0;
         end else if (abort_s || (misalign_s && (state_r == MEM_IDLE))) begin
            rd_en_mem_wb   <= 1'b0;
            mem_err_mem_wb <= 1'b1;
         end else if (stall_s) begin
            rd_en_mem_wb   <= 1'b0;
            mem_err_mem_wb <= 1'b0;
         end else begin
            rd_en_mem_wb   <= rd_en_ex_mem;
            rd_addr_mem_wb <= rd_addr_ex_mem;
            rd_data_mem_wb <= alu_data_ex_mem;
            mem_err_mem_wb <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_memory_access.sv
// Randomized bench for memory_access: each instruction is expanded into its
// expected per-cycle behaviour, which a compare process checks every cycle.
module tb_memory_access;
   import memory_access_pkg::*;

   localparam int TO = 16;
   localparam int AW = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] alu = 32'd0;
   logic [31:0] rt = 32'd0;
   logic        mem_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [4:0]  rd_addr = 5'd0;
   logic        sel = 1'b0;
   logic        mem_stall;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        wb_err;

   always #5 clk = ~clk;

   memory_access_if #(.ADDR_W(AW)) dmem ();

   memory_access #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .alu_data_ex_mem    (alu),
      .rt_data_ex_mem     (rt),
      .mem_en_ex_mem      (mem_en),
      .rd_en_ex_mem       (rd_en),
      .rd_addr_ex_mem     (rd_addr),
      .rd_data_sel_ex_mem (sel),
      .mem_stall          (mem_stall),
      .dmem               (dmem),
      .rd_en_mem_wb       (wb_en),
      .rd_addr_mem_wb     (wb_addr),
      .rd_data_mem_wb     (wb_data),
      .mem_err_mem_wb     (wb_err)
   );

   typedef struct {
      logic        req;
      logic        stall;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        en;
      logic [4:0]  waddr;
      logic [31:0] wdat;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic        cur_en = 1'b0;
   logic        cur_err = 1'b0;
   logic [4:0]  cur_addr = 5'd0;
   logic [31:0] cur_data = 32'd0;
   bit          recover_pending = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total_cnt++;
      if (act === expv) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
   endtask

   // Expected outputs for the current cycle, given the inputs now on the pins.
   task automatic push(input logic e_req, input logic e_stall);
      exp_t e;
      e.req   = e_req;
      e.stall = e_stall;
      e.we    = mem_en & ~rd_en;
      e.addr  = (alu >> 2) & 32'h3FF;
      e.wdata = rt;
      e.en    = cur_en;
      e.waddr = cur_addr;
      e.wdat  = cur_data;
      e.err   = cur_err;
      exp_q.push_back(e);
   endtask

   task automatic step(input logic e_req, input logic e_stall, input logic n_en,
                       input logic [4:0] n_addr, input logic [31:0] n_data, input logic n_err);
      push(e_req, e_stall);
      cur_en   = n_en;
      cur_addr = n_addr;
      cur_data = n_data;
      cur_err  = n_err;
      @(negedge clk);
   endtask

   task automatic bubble(input logic e_req, input logic e_stall);
      step(e_req, e_stall, 1'b0, cur_addr, cur_data, 1'b0);
   endtask

   task automatic garbage_ack();
      dmem.dmem_ack   = 1'($urandom_range(0, 1));
      dmem.dmem_rdata = $urandom;
   endtask

   // Present an instruction; a pending recovery cycle sees it held under stall.
   task automatic set_op(input logic me, input logic re, input logic sl,
                         input logic [4:0] ra, input logic [31:0] a, input logic [31:0] r);
      mem_en = me; rd_en = re; sel = sl; rd_addr = ra; alu = a; rt = r;
      if (recover_pending) begin
         garbage_ack();
         bubble(1'b0, 1'b1);
         recover_pending = 1'b0;
      end
      dmem.dmem_ack = 1'b0;
   endtask

   // w = wait cycles before ack; w >= TO means the memory never answers.
   task automatic run_access(input int w, input logic [31:0] rdv);
      if (!mem_en) begin
         garbage_ack();
         step(1'b0, 1'b0, rd_en, rd_addr, alu, 1'b0);
      end else if ((alu & 32'd3) != 32'd0) begin
         garbage_ack();
         step(1'b0, 1'b0, 1'b0, cur_addr, cur_data, 1'b1);
      end else if (w < TO) begin
         dmem.dmem_ack = 1'b0;
         for (int i = 0; i < w; i++) bubble(1'b1, 1'b1);
         dmem.dmem_ack   = 1'b1;
         dmem.dmem_rdata = rdv;
         step(1'b1, 1'b0, rd_en, rd_addr, sel ? rdv : alu, 1'b0);
      end else begin
         dmem.dmem_ack = 1'b0;
         for (int i = 0; i < TO - 1; i++) bubble(1'b1, 1'b1);
         step(1'b1, 1'b0, 1'b0, cur_addr, cur_data, 1'b1);
         recover_pending = 1'b1;
      end
      dmem.dmem_ack = 1'b0;
   endtask

   task automatic reset_cycles(input int n);
      rst_n = 1'b0;
      cur_en = 1'b0; cur_err = 1'b0; cur_addr = 5'd0; cur_data = 32'd0;
      recover_pending = 1'b0;
      for (int i = 0; i < n; i++) begin
         push(1'b0, 1'b0);
         @(negedge clk);
      end
      rst_n = 1'b1;
   endtask

   // Every-cycle comparison of DUT outputs against the queued expectations.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("req", 32'(dmem.dmem_req), 32'(e.req));
            chk("stall", 32'(mem_stall), 32'(e.stall));
            chk("we", 32'(dmem.dmem_we), 32'(e.we));
            chk("addr", 32'(dmem.dmem_addr), e.addr);
            chk("wdata", dmem.dmem_wdata, e.wdata);
            chk("wb_en", 32'(wb_en), 32'(e.en));
            chk("wb_err", 32'(wb_err), 32'(e.err));
            if (e.en) begin
               chk("wb_addr", 32'(wb_addr), 32'(e.waddr));
               chk("wb_data", wb_data, e.wdat);
            end
         end
      end
   end

   initial begin
      int w;
      logic me, re, sl;
      logic [31:0] a;
      dmem.dmem_ack   = 1'b0;
      dmem.dmem_rdata = 32'd0;
      @(negedge clk);
      reset_cycles(2);

      // Load, 0-wait ack
      set_op(1'b1, 1'b1, 1'b1, 5'd5, 32'h0000_0040, 32'h1111_2222);
      #1 chk("t1_addr", 32'(dmem.dmem_addr), 32'h0000_0010);
      run_access(0, 32'hDEAD_BEEF);
      chk("t1_wb_en", 32'(wb_en), 32'd1);
      chk("t1_wb_addr", 32'(wb_addr), 32'd5);
      chk("t1_wb_data", wb_data, 32'hDEAD_BEEF);

      // Store, ack after 3 wait cycles
      set_op(1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0008, 32'h0000_1234);
      #1 chk("t2_addr", 32'(dmem.dmem_addr), 32'h0000_0002);
      run_access(3, 32'h0);
      chk("t2_wb_en", 32'(wb_en), 32'd0);

      // Plain ALU op
      set_op(1'b0, 1'b1, 1'b0, 5'd7, 32'h0000_0055, 32'h0);
      run_access(0, 32'h0);
      chk("t3_wb_data", wb_data, 32'h0000_0055);

      // Misaligned load
      set_op(1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_0006, 32'h0);
      run_access(0, 32'h0);
      chk("t4_err", 32'(wb_err), 32'd1);
      chk("t4_wb_en", 32'(wb_en), 32'd0);

      // Load that times out
      set_op(1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_0100, 32'h0);
      run_access(TO, 32'h0);
      chk("t5_err", 32'(wb_err), 32'd1);

      // Reset in the middle of a wait, then full reissue that times out again
      set_op(1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_0080, 32'h0);
      for (int i = 0; i < 3; i++) bubble(1'b1, 1'b1);
      reset_cycles(2);
      run_access(TO, 32'h0);

      for (int n = 0; n < 250; n++) begin
         me = ($urandom_range(0, 9) < 7);
         re = 1'($urandom_range(0, 1));
         sl = re & me & 1'($urandom_range(0, 1));
         a  = $urandom;
         if ($urandom_range(0, 9) < 8) a = a & 32'hFFFF_FFFC;
         w  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, TO + 1));
         set_op(me, re, sl, 5'($urandom), a, $urandom);
         run_access(w, $urandom);
      end

      set_op(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
      run_access(0, 32'h0);
      #5;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
